// File: rtl/poly_accel_pkg.sv
// Shared definitions for the polynomial accelerator command interface:
// opcodes, command token field positions and the token pack helper.
package poly_accel_pkg;

    localparam logic [7:0] OP_STP = 8'd0;
    localparam logic [7:0] OP_EVP = 8'd1;
    localparam logic [7:0] OP_EVB = 8'd2;
    localparam logic [7:0] OP_RST = 8'd3;

    localparam int CMD_W     = 16;
    localparam int INSTR_LSB = 0;
    localparam int INSTR_MSB = 7;
    localparam int ARG1_LSB  = 8;
    localparam int ARG1_MSB  = 10;
    localparam int ARG2_LSB  = 11;
    localparam int ARG2_MSB  = 15;

    // Largest operand stream is STP with N=31, i.e. 32 coefficients.
    localparam int REM_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CMD  = 2'd2
    } issue_state_t;

    function automatic logic [CMD_W-1:0] pack_command(input logic [7:0] instr,
                                                      input logic [2:0] arg1,
                                                      input logic [4:0] arg2);
        logic [CMD_W-1:0] c;
        c = '0;
        c[INSTR_MSB:INSTR_LSB] = instr;
        c[ARG1_MSB:ARG1_LSB]   = arg1;
        c[ARG2_MSB:ARG2_LSB]   = arg2;
        return c;
    endfunction

    // Unknown opcodes carry no operands so they can still be forwarded verbatim.
    function automatic logic [REM_W-1:0] operand_count(input logic [7:0] instr,
                                                       input logic [4:0] arg2);
        logic [REM_W-1:0] n;
        case (instr)
            OP_STP:  n = {1'b0, arg2} + 6'd1;
            OP_EVP:  n = 6'd1;
            OP_EVB:  n = {1'b0, arg2};
            default: n = 6'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/poly_cmd_issuer.sv
// Host-side command issuer: streams operand tokens to the data FIFO, then the packed command token.
// Optional request checking (bad opcode / slot) is enabled by defining ISSUE_CHECK_EN.
module poly_cmd_issuer
    import poly_accel_pkg::*;
#(
    parameter int word_size = 16,
    parameter int n_size    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_instr,
    input  logic [2:0]           req_arg1,
    input  logic [4:0]           req_arg2,
    input  logic                 src_valid,
    input  logic [word_size-1:0] src_data,
    output logic                 src_ready,
    input  logic [word_size-1:0] free_data,
    input  logic [word_size-1:0] free_command,
    output logic                 wr_en_data,
    output logic [word_size-1:0] data_out,
    output logic                 wr_en_command,
    output logic [word_size-1:0] command_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          issued_count
);

    issue_state_t     state;
    issue_state_t     state_nxt;
    logic [7:0]       instr_q;
    logic [2:0]       arg1_q;
    logic [4:0]       arg2_q;
    logic [REM_W-1:0] remaining;
    logic [REM_W-1:0] load_count;
    logic             req_fire;
    logic             req_bad;
    logic             req_take;
    logic             src_fire;
    logic             cmd_fire;
    logic             data_room;

    assign load_count = operand_count(req_instr, req_arg2);
    assign req_fire   = req_valid && req_ready;
    assign req_take   = req_fire && !req_bad;
    assign src_fire   = src_valid && src_ready;

`ifdef ISSUE_CHECK_EN
    logic [31:0] arg1_ext;
    assign arg1_ext = 32'(req_arg1);
    assign req_bad  = (req_instr > OP_RST) || (arg1_ext >= 32'(n_size));
`else
    logic unused_cfg;
    assign unused_cfg = (n_size == 0);
    assign req_bad    = 1'b0;
`endif

    // The write issued last cycle is not yet reflected in free_data.
    assign data_room = (free_data >= word_size'(2)) ||
                       ((free_data == word_size'(1)) && !wr_en_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_take) begin
                    state_nxt = (load_count == '0) ? ST_CMD : ST_DATA;
                end
            end
            ST_DATA: begin
                if (src_fire && (remaining == 6'd1)) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cmd_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command waits for the last data strobe to retire so operands always land first.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        src_ready = 1'b0;
        cmd_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_DATA: begin
                src_ready = data_room;
            end
            ST_CMD: begin
                cmd_fire = (free_command != '0) && !wr_en_data;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q       <= '0;
            arg1_q        <= '0;
            arg2_q        <= '0;
            remaining     <= '0;
            wr_en_data    <= 1'b0;
            data_out      <= '0;
            wr_en_command <= 1'b0;
            command_out   <= '0;
            done          <= 1'b0;
            issued_count  <= '0;
        end else begin
            wr_en_data    <= src_fire;
            wr_en_command <= cmd_fire;
            done          <= cmd_fire;
            if (req_take) begin
                instr_q   <= req_instr;
                arg1_q    <= req_arg1;
                arg2_q    <= req_arg2;
                remaining <= load_count;
            end else if (src_fire) begin
                remaining <= remaining - 6'd1;
            end
            if (src_fire) begin
                data_out <= src_data;
            end
            if (cmd_fire) begin
                command_out  <= word_size'(pack_command(instr_q, arg1_q, arg2_q));
                issued_count <= issued_count + 16'd1;
            end
        end
    end

`ifdef ISSUE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= req_fire && req_bad;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_cmd_issuer.sv
// Directed self-checking bench for poly_cmd_issuer.
module tb_poly_cmd_issuer;

    localparam int WS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_instr;
    logic [2:0]    req_arg1;
    logic [4:0]    req_arg2;
    logic          src_valid;
    logic [WS-1:0] src_data;
    logic          src_ready;
    logic [WS-1:0] free_data;
    logic [WS-1:0] free_command;
    logic          wr_en_data;
    logic [WS-1:0] data_out;
    logic          wr_en_command;
    logic [WS-1:0] command_out;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   issued_count;

    poly_cmd_issuer #(.word_size(WS), .n_size(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_arg1(req_arg1), .req_arg2(req_arg2),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .free_data(free_data), .free_command(free_command),
        .wr_en_data(wr_en_data), .data_out(data_out),
        .wr_en_command(wr_en_command), .command_out(command_out),
        .busy(busy), .done(done), .err(err), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int exp_issued = 0;
    int done_bad = 0;

    logic [15:0] data_log[$];
    int          data_cyc[$];
    logic [15:0] cmd_log[$];
    int          cmd_cyc[$];

    always @(negedge clk) begin
        if (wr_en_data === 1'b1) begin
            data_log.push_back(data_out);
            data_cyc.push_back(cyc);
        end
        if (wr_en_command === 1'b1) begin
            cmd_log.push_back(command_out);
            cmd_cyc.push_back(cyc);
        end
        if (done !== wr_en_command) done_bad++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        data_log.delete();
        data_cyc.delete();
        cmd_log.delete();
        cmd_cyc.delete();
    endtask

    task automatic issue(input logic [7:0] i, input logic [2:0] a1, input logic [4:0] a2, output int hs);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready got=%b want=1", req_ready);
        end
        req_valid = 1'b1;
        req_instr = i;
        req_arg1  = a1;
        req_arg2  = a2;
        tick();
        hs = cyc;
        req_valid = 1'b0;
    endtask

    task automatic feed(input int n, input logic [15:0] base, input int budget);
        int  i;
        int  t;
        logic acc;
        i = 0;
        t = 0;
        while (i < n && t < budget) begin
            src_valid = 1'b1;
            src_data  = base + 16'(i);
            @(negedge clk);
            acc = src_ready;
            tick();
            if (acc) i++;
            t++;
        end
        src_valid = 1'b0;
        checks++;
        if (i != n) begin
            failures++;
            $display("FAIL feed_count got=%0d want=%0d", i, n);
        end
    endtask

    task automatic check_cmd(input string name, input logic [15:0] want);
        checks++;
        if (cmd_log.size() != 1) begin
            failures++;
            $display("FAIL %s_cmd_count got=%0d want=1", name, cmd_log.size());
        end else if (cmd_log[0] !== want) begin
            failures++;
            $display("FAIL %s_cmd got=%h want=%h", name, cmd_log[0], want);
        end
    endtask

    task automatic check_data_count(input string name, input int want);
        checks++;
        if (data_log.size() != want) begin
            failures++;
            $display("FAIL %s_data_count got=%0d want=%0d", name, data_log.size(), want);
        end
    endtask

    task automatic check_issued(input string name);
        checks++;
        if (issued_count !== 16'(exp_issued)) begin
            failures++;
            $display("FAIL %s_issued got=%0d want=%0d", name, issued_count, exp_issued);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({req_ready, busy, wr_en_data, wr_en_command, done, err} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=100000",
                     {req_ready, busy, wr_en_data, wr_en_command, done, err});
        end
        checks++;
        if ({data_out, command_out, issued_count} !== 48'h0) begin
            failures++;
            $display("FAIL reset_values got=%h want=0", {data_out, command_out, issued_count});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rst_cmd();
        int hs;
        clear_logs();
        issue(8'd3, 3'd0, 5'd0, hs);
        repeat (4) tick();
        exp_issued++;
        check_cmd("rst", 16'h0003);
        check_data_count("rst", 0);
        checks++;
        if (cmd_cyc.size() != 1 || cmd_cyc[0] != hs + 1) begin
            failures++;
            $display("FAIL rst_latency got_cycles=%0d want=%0d", cmd_cyc.size() ? cmd_cyc[0] - hs + 1 : -1, 2);
        end
        check_issued("rst");
    endtask

    task automatic test_stp();
        int hs;
        clear_logs();
        issue(8'd0, 3'd2, 5'd3, hs);
        feed(4, 16'h0001, 20);
        repeat (4) tick();
        exp_issued++;
        check_data_count("stp", 4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (data_log.size() != 4 || data_log[k] !== 16'(k + 1)) begin
                failures++;
                $display("FAIL stp_data%0d got=%h want=%h", k, data_log.size() == 4 ? data_log[k] : 16'hxxxx, k + 1);
            end
        end
        checks++;
        if (data_cyc.size() != 4 || data_cyc[0] != hs + 1 || data_cyc[3] != hs + 4) begin
            failures++;
            $display("FAIL stp_consecutive got_first=%0d want=%0d", data_cyc.size() ? data_cyc[0] : -1, hs + 1);
        end
        check_cmd("stp", 16'h1A00);
        checks++;
        if (cmd_cyc.size() != 1 || data_cyc.size() != 4 || cmd_cyc[0] != data_cyc[3] + 2) begin
            failures++;
            $display("FAIL stp_cmd_order got=%0d want=%0d", cmd_cyc.size() ? cmd_cyc[0] : -1,
                     data_cyc.size() == 4 ? data_cyc[3] + 2 : -1);
        end
        check_issued("stp");
    endtask

    task automatic test_evb_zero();
        int hs;
        clear_logs();
        issue(8'd2, 3'd1, 5'd0, hs);
        repeat (4) tick();
        exp_issued++;
        check_cmd("evb0", 16'h0102);
        check_data_count("evb0", 0);
        check_issued("evb0");
    endtask

    task automatic test_evb_stall();
        int hs;
        clear_logs();
        free_data = 16'd1;
        issue(8'd2, 3'd3, 5'd5, hs);
        fork
            feed(5, 16'h00A0, 80);
            begin
                int n;
                n = 0;
                while (data_log.size() == 0 && n < 20) begin
                    tick();
                    n++;
                end
                free_data = 16'd0;
                repeat (8) tick();
                check_data_count("evb_stall", 1);
                checks++;
                if (busy !== 1'b1 || cmd_log.size() != 0) begin
                    failures++;
                    $display("FAIL evb_stall_state got_busy=%b got_cmds=%0d want=1/0", busy, cmd_log.size());
                end
                free_data = 16'd16;
            end
        join
        repeat (4) tick();
        exp_issued++;
        check_data_count("evb5", 5);
        checks++;
        if (data_log.size() != 5 || data_log[4] !== 16'h00A4) begin
            failures++;
            $display("FAIL evb5_last_data got=%h want=00a4", data_log.size() == 5 ? data_log[4] : 16'hxxxx);
        end
        check_cmd("evb5", 16'h2B02);
        check_issued("evb5");
    endtask

    task automatic test_cmd_backpressure();
        int hs;
        int f;
        clear_logs();
        free_command = 16'd0;
        issue(8'd1, 3'd4, 5'd0, hs);
        feed(1, 16'h1234, 10);
        repeat (10) tick();
        check_data_count("evp_hold", 1);
        checks++;
        if (cmd_log.size() != 0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL evp_hold got_cmds=%0d busy=%b ready=%b want=0/1/0", cmd_log.size(), busy, req_ready);
        end
        free_command = 16'd1;
        f = cyc;
        repeat (3) tick();
        free_command = 16'd16;
        exp_issued++;
        check_cmd("evp", 16'h0401);
        checks++;
        if (cmd_cyc.size() != 1 || cmd_cyc[0] != f + 1) begin
            failures++;
            $display("FAIL evp_release got=%0d want=%0d", cmd_cyc.size() ? cmd_cyc[0] : -1, f + 1);
        end
        checks++;
        if (data_log.size() != 1 || data_log[0] !== 16'h1234) begin
            failures++;
            $display("FAIL evp_data got=%h want=1234", data_log.size() ? data_log[0] : 16'hxxxx);
        end
    endtask

    task automatic test_mid_reset();
        int hs;
        clear_logs();
        issue(8'd0, 3'd5, 5'd5, hs);
        feed(2, 16'h0100, 10);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        exp_issued = 0;
        checks++;
        if ({wr_en_data, wr_en_command, done, req_ready, busy} !== 5'b00010) begin
            failures++;
            $display("FAIL midrst_flags got=%b want=00010", {wr_en_data, wr_en_command, done, req_ready, busy});
        end
        check_issued("midrst");
        rst = 1'b0;
        src_valid = 1'b1;
        src_data = 16'hDEAD;
        repeat (20) tick();
        src_valid = 1'b0;
        check_data_count("midrst", 2);
        checks++;
        if (cmd_log.size() != 0) begin
            failures++;
            $display("FAIL midrst_cmds got=%0d want=0", cmd_log.size());
        end
    endtask

    task automatic test_unknown_instr();
        int hs;
        clear_logs();
`ifdef ISSUE_CHECK_EN
        issue(8'h07, 3'd1, 5'd0, hs);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL chk_err got=%b want=1", err);
        end
        tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL chk_err_pulse got_err=%b busy=%b want=0/0", err, busy);
        end
        repeat (3) tick();
        checks++;
        if (cmd_log.size() != 0 || data_log.size() != 0) begin
            failures++;
            $display("FAIL chk_writes got=%0d want=0", cmd_log.size() + data_log.size());
        end
        check_issued("chk");
        issue(8'd3, 3'd7, 5'd0, hs);
        repeat (4) tick();
        exp_issued++;
        check_cmd("chk_slot7", 16'h0703);
`else
        issue(8'h07, 3'd7, 5'd9, hs);
        repeat (4) tick();
        exp_issued++;
        check_cmd("unk", 16'h4F07);
        check_data_count("unk", 0);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL unk_err got=%b want=0", err);
        end
`endif
        check_issued("unk");
    endtask

    task automatic test_back_to_back();
        int hs;
        clear_logs();
        issue(8'd3, 3'd1, 5'd0, hs);
        issue(8'd3, 3'd2, 5'd31, hs);
        repeat (4) tick();
        exp_issued += 2;
        checks++;
        if (cmd_log.size() != 2 || cmd_log[0] !== 16'h0103 || cmd_log[1] !== 16'hFA03) begin
            failures++;
            $display("FAIL b2b_cmds got_n=%0d got0=%h got1=%h want=0103/fa03", cmd_log.size(),
                     cmd_log.size() > 0 ? cmd_log[0] : 16'hxxxx, cmd_log.size() > 1 ? cmd_log[1] : 16'hxxxx);
        end
        check_issued("b2b");
        checks++;
        if (done_bad != 0) begin
            failures++;
            $display("FAIL done_tracks_cmd got=%0d want=0", done_bad);
        end
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_instr    = '0;
        req_arg1     = '0;
        req_arg2     = '0;
        src_valid    = 1'b0;
        src_data     = '0;
        free_data    = 16'd16;
        free_command = 16'd16;
        test_reset();
        test_rst_cmd();
        test_stp();
        test_evb_zero();
        test_evb_stall();
        test_cmd_backpressure();
        test_mid_reset();
        test_unknown_instr();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
